// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the five-stage pipeline: derives per-register
// write enables, bubble flushes and PC enable each cycle, runs the halt drain
// sequence and keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dreq,
    input  logic             exmem_halt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ex_redirect,
    output logic             pc_wen,
    output logic             imem_ren,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             dmiss, load_use;

    assign dmiss    = exmem_dreq && !dhit;
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Per-cycle control decode; RUN overrides are strictly prioritised.
    always_comb begin
        state_d     = state_q;
        pc_wen      = 1'b0;
        imem_ren    = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            StRun: begin
                pc_wen    = 1'b1;
                imem_ren  = 1'b1;
                ifid_wen  = 1'b1;
                idex_wen  = 1'b1;
                exmem_wen = 1'b1;
                memwb_wen = 1'b1;
                if (dmiss) begin
                    // Freeze everything upstream of MEM/WB; a pending redirect re-presents.
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_wen    = 1'b0;
                    exmem_wen   = 1'b0;
                    memwb_flush = 1'b1;
                end else if (exmem_halt) begin
                    pc_wen      = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = StDrain;
                end else if (ex_redirect) begin
                    // PC loads the target even on an I-miss.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                end
                stall_inc = !pc_wen;
            end
            StDrain: begin
                memwb_flush = 1'b1;
                state_d     = StHalted;
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: state_d = StRun;
        endcase
        // Outputs sit at their reset values for as long as reset is held.
        if (!nRST) begin
            pc_wen      = 1'b0;
            imem_ren    = 1'b0;
            ifid_wen    = 1'b0;
            idex_wen    = 1'b0;
            exmem_wen   = 1'b0;
            memwb_wen   = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
            halted      = 1'b0;
        end
    end

    // State register and saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised scoreboard bench: two instances (16-bit and 4-bit counters) share
// stimulus; a reference model pushes expected responses, a monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [10:0] ctl;
        logic [15:0] s16;
        logic [15:0] f16;
        logic [3:0]  s4;
        logic [3:0]  f4;
    } exp_t;

    logic       CLK, nRST;
    logic       ihit, dhit, exmem_dreq, exmem_halt, idex_memread, ex_redirect;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    logic        a_pc, a_im, a_w0, a_w1, a_w2, a_w3, a_f0, a_f1, a_f2, a_f3, a_h;
    logic        b_pc, b_im, b_w0, b_w1, b_w2, b_w3, b_f0, b_f1, b_f2, b_f3, b_h;
    logic [15:0] a_sc, a_fc;
    logic [3:0]  b_sc, b_fc;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    pipeline_hazard_ctrl #(.CNT_W(16)) dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dreq(exmem_dreq),
        .exmem_halt(exmem_halt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect),
        .pc_wen(a_pc), .imem_ren(a_im), .ifid_wen(a_w0), .idex_wen(a_w1),
        .exmem_wen(a_w2), .memwb_wen(a_w3), .ifid_flush(a_f0), .idex_flush(a_f1),
        .exmem_flush(a_f2), .memwb_flush(a_f3), .halted(a_h),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dreq(exmem_dreq),
        .exmem_halt(exmem_halt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect),
        .pc_wen(b_pc), .imem_ren(b_im), .ifid_wen(b_w0), .idex_wen(b_w1),
        .exmem_wen(b_w2), .memwb_wen(b_w3), .ifid_flush(b_f0), .idex_flush(b_f1),
        .exmem_flush(b_f2), .memwb_flush(b_f3), .halted(b_h),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [10:0] ctl_a();
        return {a_pc, a_im, a_w0, a_w1, a_w2, a_w3, a_f0, a_f1, a_f2, a_f3, a_h};
    endfunction

    function automatic logic [10:0] ctl_b();
        return {b_pc, b_im, b_w0, b_w1, b_w2, b_w3, b_f0, b_f1, b_f2, b_f3, b_h};
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare both instances against the next expected response.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("ctl16", {5'd0, ctl_a()}, {5'd0, e.ctl});
            cmp("ctl4", {5'd0, ctl_b()}, {5'd0, e.ctl});
            cmp("stall16", a_sc, e.s16);
            cmp("flush16", a_fc, e.f16);
            cmp("stall4", {12'd0, b_sc}, {12'd0, e.s4});
            cmp("flush4", {12'd0, b_fc}, {12'd0, e.f4});
        end
    end

    // Reference model state: phase 0 running, 1 draining, 2 halted; raw event counts.
    int phase, stall_ev, flush_ev;

    function automatic logic [15:0] sat(input int ev, input int w);
        int lim;
        lim = (1 << w) - 1;
        return 16'((ev > lim) ? lim : ev);
    endfunction

    task automatic model_step();
        exp_t e;
        // Named fields of the expected control word.
        logic pc, im, w0, w1, w2, w3, f0, f1, f2, f3, h;
        logic lu;
        e.s16 = sat(stall_ev, 16);
        e.f16 = sat(flush_ev, 16);
        e.s4  = 4'(sat(stall_ev, 4));
        e.f4  = 4'(sat(flush_ev, 4));
        {pc, im, w0, w1, w2, w3, f0, f1, f2, f3, h} = '0;
        lu = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (phase == 0) begin
            {pc, im, w0, w1, w2, w3} = 6'b111111;
            if (exmem_dreq && !dhit) begin
                pc = 0; w0 = 0; w1 = 0; w2 = 0; f3 = 1;
            end else if (exmem_halt) begin
                pc = 0; f0 = 1; f1 = 1; f2 = 1;
                phase = 1;
            end else if (ex_redirect) begin
                f0 = 1; f1 = 1;
                flush_ev++;
            end else if (lu) begin
                pc = 0; w0 = 0; f1 = 1;
            end else if (!ihit) begin
                pc = 0; f0 = 1;
            end
            if (!pc) stall_ev++;
        end else if (phase == 1) begin
            f3 = 1;
            phase = 2;
        end else begin
            h = 1;
        end
        e.ctl = {pc, im, w0, w1, w2, w3, f0, f1, f2, f3, h};
        q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_ctl16"}, {5'd0, ctl_a()}, 16'd0);
        cmp({tag, "_ctl4"}, {5'd0, ctl_b()}, 16'd0);
        cmp({tag, "_cnt16"}, a_sc | a_fc, 16'd0);
        cmp({tag, "_cnt4"}, {12'd0, b_sc | b_fc}, 16'd0);
    endtask

    initial begin
        nRST = 1'b0;
        {ihit, dhit, exmem_dreq, exmem_halt, idex_memread, ex_redirect} = '0;
        idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        #3;
        check_reset("por");
        for (int ep = 0; ep < 8; ep++) begin
            phase = 0; stall_ev = 0; flush_ev = 0;
            for (int i = 0; i < 150; i++) begin
                @(posedge CLK);
                #1;
                nRST         = 1'b1;
                ihit         = ($urandom_range(0, 3) != 0);
                dhit         = ($urandom_range(0, 9) < 7);
                exmem_dreq   = ($urandom_range(0, 1) == 1);
                ex_redirect  = ($urandom_range(0, 3) == 0);
                idex_memread = ($urandom_range(0, 9) < 4);
                idex_rt      = 5'($urandom_range(0, 3));
                ifid_rs      = 5'($urandom_range(0, 3));
                ifid_rt      = 5'($urandom_range(0, 3));
                exmem_halt   = (ep != 0) && ($urandom_range(0, 59) == 0);
                model_step();
            end
            // Async reset mid-cycle: outputs and counters must clear without an edge.
            @(posedge CLK);
            #2;
            nRST = 1'b0;
            #1;
            check_reset("async");
        end
        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses unchecked, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it derives per-register WEN/flush and PC enable from cache hit status, load-use hazards, EX-stage redirects and halt. It owns the halt drain FSM and saturating stall/flush performance counters. It drives the `WEN` and `flush` inputs of the ID/EX register and its siblings.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters (saturating).

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction cache returned valid instruction this cycle
dhit  in  1  data cache completed the EX/MEM access this cycle
exmem_dreq  in  1  EX/MEM stage holds a load or store (dREN|dWEN)
exmem_halt  in  1  halt instruction in EX/MEM
idex_memread  in  1  ID/EX holds a load (M_MemRead)
idex_rt  in  5  ID/EX destination rt
ifid_rs  in  5  IF/ID source rs
ifid_rt  in  5  IF/ID source rt
ex_redirect  in  1  taken branch or jump resolved in EX
pc_wen  out  1  PC update enable
imem_ren  out  1  instruction fetch request
ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  register write enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble-insert; a flushed register zeroes its control fields
halted  out  1  processor halted (sticky)
stall_cnt  out  CNT_W  cycles with pc_wen=0 while in RUN
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (nRST low, async): state=RUN. All wen=0, all flush=0. pc_wen=0, imem_ren=0, halted=0, counters=0.
- Outputs are combinational from the state and inputs. State and counters are registered.
- FSM states: RUN, DRAIN, HALTED.
- RUN: default is all wen=1, flush=0, pc_wen=1, imem_ren=1. Overrides apply by strict priority; only the highest applies:
  1. D-miss (exmem_dreq && !dhit): pc_wen, ifid_wen, idex_wen and exmem_wen = 0; memwb_flush=1. The pipeline freezes and redirect, load-use and halt are ignored this cycle. A frozen ex_redirect re-presents next cycle.
  2. Halt (exmem_halt): memwb_wen=1, which captures the halt. pc_wen=0; ifid_flush=idex_flush=exmem_flush=1. Next state is DRAIN.
  3. Redirect (ex_redirect): pc_wen=1, which loads the target even if ihit=0. ifid_flush=idex_flush=1. flush_cnt increments.
  4. Load-use (idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt)): pc_wen=0, ifid_wen=0, idex_flush=1. This lasts exactly one cycle because ID/EX becomes a bubble.
  5. I-miss (!ihit): pc_wen=0, ifid_flush=1; downstream registers advance.
- stall_cnt increments in RUN whenever pc_wen=0 (cases 1, 2, 4 and 5). Both counters saturate at all-ones and never wrap.
- DRAIN: lasts one cycle so MEM/WB writeback commits. All wen=0, memwb_flush=1, pc_wen=0, imem_ren=0. Next state is HALTED.
- HALTED: all wen=0, flush=0, pc_wen=0, imem_ren=0, halted=1. The state is held until nRST, and all inputs are ignored.
- Where flush and wen are both 1, the flush wins in the register.
- Reset asserted mid-stall or mid-DRAIN returns to RUN immediately (async). Counters clear.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 -> one cycle of pc_wen=0, ifid_wen=0, idex_flush=1; next cycle all wen=1; stall_cnt=1.
- Load to $0: idex_rt=0, ifid_rs=0 -> no stall; pc_wen=1.
- D-miss with redirect: exmem_dreq=1, dhit=0 for 3 cycles with ex_redirect=1 -> 3 frozen cycles, memwb_flush=1. Cycle 4 (dhit=1) -> ifid_flush=idex_flush=1, pc_wen=1; flush_cnt=1.
- Redirect with I-miss: ex_redirect=1, ihit=0 -> pc_wen=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
- Halt: exmem_halt=1 -> cycle 0 memwb_wen=1 and upstream flushes; cycle 1 DRAIN; cycle 2 onward halted=1 and all wen=0. Pulsing ihit/ex_redirect has no effect until nRST.
- Saturation: CNT_W=4 with ihit=0 for 20 cycles -> stall_cnt=15 and holds. Async nRST pulse mid-run -> counters 0 and all outputs at reset values without a clock edge.
